// File: rtl/ref_row_streamer.sv
// Reference-window row streamer: fetches 15 rows of 15 pixels from word-wide frame
// memory, aligns and edge-replicates each row, and hands it to the interpolator.
//
// state   | meaning
// IDLE    | waiting for start
// REQ     | issue one memory read for word w of row r
// WAIT    | waiting for mem_rvalid, store word in slot w
// PRESENT | row assembled, row_valid high until row_ready
// FIN     | one-cycle done pulse
module ref_row_streamer #(
    parameter int FRAME_W = 64,
    parameter int FRAME_H = 64,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        x0,
    input  logic [7:0]        y0,
    output logic              busy,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic [119:0]      in_row,
    output logic              row_valid,
    input  logic              row_ready,
    output logic [3:0]        row_idx,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, PRESENT, FIN} state_t;

    state_t      state, state_nxt;
    logic [7:0]  x0_q, y0_q, x0_nxt, y0_nxt;
    logic [3:0]  r_q, r_nxt;
    logic [1:0]  w_q, w_nxt;
    logic        slot_we;
    logic [63:0] slot [3];

    logic [8:0]   x_end, x_last, y_sum, ry, edge_sel;
    logic [5:0]   w_diff;
    logic [1:0]   w_last;
    logic [31:0]  addr_full;
    logic [191:0] cat, shifted;
    logic [7:0]   edge_pix;
    logic [119:0] row_asm;

    // Index of the last word needed for the current row, relative to x0>>3
    always_comb begin
        x_end  = {1'b0, x0_q} + 9'd14;
        x_last = (x_end > 9'(FRAME_W - 1)) ? 9'(FRAME_W - 1) : x_end;
        w_diff = x_last[8:3] - {1'b0, x0_q[7:3]};
        w_last = w_diff[1:0];
    end

    always_comb begin
        state_nxt = state;
        x0_nxt    = x0_q;
        y0_nxt    = y0_q;
        r_nxt     = r_q;
        w_nxt     = w_q;
        slot_we   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    x0_nxt    = x0;
                    y0_nxt    = y0;
                    r_nxt     = 4'd0;
                    w_nxt     = 2'd0;
                    state_nxt = REQ;
                end
            end
            REQ: state_nxt = WAIT;
            WAIT: begin
                if (mem_rvalid) begin
                    slot_we = 1'b1;
                    if (w_q < w_last) begin
                        w_nxt     = w_q + 2'd1;
                        state_nxt = REQ;
                    end else begin
                        state_nxt = PRESENT;
                    end
                end
            end
            PRESENT: begin
                if (row_ready) begin
                    if (r_q == 4'd14) begin
                        state_nxt = FIN;
                    end else begin
                        r_nxt     = r_q + 4'd1;
                        w_nxt     = 2'd0;
                        state_nxt = REQ;
                    end
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address of the next read, computed from the values the FSM is about to hold
    always_comb begin
        y_sum     = {1'b0, y0_nxt} + {5'd0, r_nxt};
        ry        = (y_sum > 9'(FRAME_H - 1)) ? 9'(FRAME_H - 1) : y_sum;
        addr_full = 32'(ry) * 32'(FRAME_W / 8) + 32'(x0_nxt[7:3]) + 32'(w_nxt);
    end

    // Row assembly sees the word arriving this cycle as if it were already in its slot
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            cat[64*k +: 64] = (w_q == 2'(k)) ? mem_rdata : slot[k];
        end
        shifted  = cat >> {x0_q[2:0], 3'b000};
        edge_sel = 9'(FRAME_W - 1) - {1'b0, x0_q};
        edge_pix = shifted[{edge_sel[3:0], 3'b000} +: 8];
        for (int i = 0; i < 15; i++) begin
            row_asm[8*i +: 8] = (({1'b0, x0_q} + 9'(i)) >= 9'(FRAME_W)) ? edge_pix
                                                                       : shifted[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            r_q       <= '0;
            w_q       <= '0;
            slot[0]   <= '0;
            slot[1]   <= '0;
            slot[2]   <= '0;
            busy      <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            in_row    <= '0;
            row_valid <= 1'b0;
            row_idx   <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            x0_q      <= x0_nxt;
            y0_q      <= y0_nxt;
            r_q       <= r_nxt;
            w_q       <= w_nxt;
            if (slot_we) slot[w_q] <= mem_rdata;
            busy      <= (state_nxt == REQ) || (state_nxt == WAIT) || (state_nxt == PRESENT);
            mem_rd    <= (state_nxt == REQ);
            if (state_nxt == REQ) mem_addr <= addr_full[ADDR_W-1:0];
            if (state == WAIT && mem_rvalid && state_nxt == PRESENT) in_row <= row_asm;
            row_valid <= (state_nxt == PRESENT);
            row_idx   <= r_nxt;
            done      <= (state_nxt == FIN);
        end
    end

endmodule
